circuito_exp5: RTL and testbench

//  Memory-sequence game ("Genius"), top level of experiment 5. Round k (k=0..15) requires the player
//  to repeat ROM entries 0..k on the four buttons. 16 correct rounds -> ganhou.
//  A wrong button or no press for TIMEOUT cycles -> perdeu.

---
 rtl/circuito_exp5.sv | 190 +++++++++++++++++++
 tb/tb_circuito_exp5.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/circuito_exp5.sv
// Genius memory-sequence game, experiment 5 top level: sequencing FSM, address/limit
// counters, button edge detector, jogada register, 16x4 ROM, press timeout, 7-seg debug.
//
// state          | meaning
// 0 inicial      | idle, waiting for jogar
// 1 preparacao   | clear address, limit and jogada register
// 2 nova_seq     | start of a round, address back to 0
// 3 espera_jogada| waiting for a button press, timeout running
// 4 registra     | capture buttons into jogada register
// 5 comparacao   | check jogada against ROM and decide next step
// 6 proxima_jogada | advance address within the round
// 7 proxima_seq  | extend the sequence by one entry
// A fim_ganhou   | all 16 rounds correct
// D fim_timeout  | no press within the timeout window
// E fim_errou    | wrong button
module circuito_exp5 #(
  parameter int TIMEOUT = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic [3:0] botoes,
  output logic       ganhou,
  output logic       perdeu,
  output logic       pronto,
  output logic [3:0] leds,
  output logic       db_igual,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_estado,
  output logic [6:0] db_jogadafeita,
  output logic [6:0] db_sequencia,
  output logic       db_clock,
  output logic       db_iniciar,
  output logic       db_fimseq,
  output logic       db_igualseq,
  output logic       db_igualjogada,
  output logic       db_tem_jogada,
  output logic       db_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    NOVA_SEQ       = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMA_SEQ    = 4'h7,
    FIM_GANHOU     = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERROU      = 4'hE
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      endereco, limite, jogada, rom_dado;
  logic [TW-1:0]   tmo_cnt;
  logic            botoes_q, tem_jogada, igualjogada, igualseq, fimseq, tmo_fim;

  function automatic logic [3:0] rom_ler(input logic [3:0] a);
    case (a)
      4'd0:    rom_ler = 4'b0001;
      4'd1:    rom_ler = 4'b0010;
      4'd2:    rom_ler = 4'b0100;
      4'd3:    rom_ler = 4'b1000;
      4'd4:    rom_ler = 4'b0100;
      4'd5:    rom_ler = 4'b0010;
      4'd6:    rom_ler = 4'b0001;
      4'd7:    rom_ler = 4'b0001;
      4'd8:    rom_ler = 4'b0010;
      4'd9:    rom_ler = 4'b0010;
      4'd10:   rom_ler = 4'b0100;
      4'd11:   rom_ler = 4'b0100;
      4'd12:   rom_ler = 4'b1000;
      4'd13:   rom_ler = 4'b1000;
      4'd14:   rom_ler = 4'b0001;
      default: rom_ler = 4'b0100;
    endcase
  endfunction

  // active-low segments, gfedcba
  function automatic logic [6:0] hex7seg(input logic [3:0] d);
    case (d)
      4'h0:    hex7seg = 7'h40;
      4'h1:    hex7seg = 7'h79;
      4'h2:    hex7seg = 7'h24;
      4'h3:    hex7seg = 7'h30;
      4'h4:    hex7seg = 7'h19;
      4'h5:    hex7seg = 7'h12;
      4'h6:    hex7seg = 7'h02;
      4'h7:    hex7seg = 7'h78;
      4'h8:    hex7seg = 7'h00;
      4'h9:    hex7seg = 7'h10;
      4'hA:    hex7seg = 7'h08;
      4'hB:    hex7seg = 7'h03;
      4'hC:    hex7seg = 7'h46;
      4'hD:    hex7seg = 7'h21;
      4'hE:    hex7seg = 7'h06;
      default: hex7seg = 7'h0E;
    endcase
  endfunction

  assign rom_dado    = rom_ler(endereco);
  assign tem_jogada  = (|botoes) & ~botoes_q;
  assign igualjogada = (jogada == rom_dado);
  assign igualseq    = (endereco == limite);
  assign fimseq      = (limite == 4'd15);
  assign tmo_fim     = (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      INICIAL:        if (jogar) state_nxt = PREPARACAO;
      PREPARACAO:     state_nxt = NOVA_SEQ;
      NOVA_SEQ:       state_nxt = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (tem_jogada)   state_nxt = REGISTRA;
        else if (tmo_fim) state_nxt = FIM_TIMEOUT;
      end
      REGISTRA:       state_nxt = COMPARACAO;
      COMPARACAO: begin
        if (!igualjogada)           state_nxt = FIM_ERROU;
        else if (igualseq && fimseq) state_nxt = FIM_GANHOU;
        else if (igualseq)          state_nxt = PROXIMA_SEQ;
        else                        state_nxt = PROXIMA_JOGADA;
      end
      PROXIMA_JOGADA: state_nxt = ESPERA_JOGADA;
      PROXIMA_SEQ:    state_nxt = NOVA_SEQ;
      FIM_GANHOU, FIM_TIMEOUT, FIM_ERROU:
        if (jogar) state_nxt = PREPARACAO;
      default:        state_nxt = INICIAL;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= INICIAL;
      endereco   <= '0;
      limite     <= '0;
      jogada     <= '0;
      tmo_cnt    <= '0;
      botoes_q   <= 1'b0;
      ganhou     <= 1'b0;
      perdeu     <= 1'b0;
      pronto     <= 1'b0;
      db_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      botoes_q <= |botoes;
      tmo_cnt  <= (state == ESPERA_JOGADA) ? tmo_cnt + 1'b1 : '0;
      case (state)
        PREPARACAO: begin
          endereco <= '0;
          limite   <= '0;
          jogada   <= '0;
        end
        NOVA_SEQ:       endereco <= '0;
        REGISTRA:       jogada   <= botoes;
        PROXIMA_JOGADA: endereco <= endereco + 4'd1;
        PROXIMA_SEQ:    limite   <= limite + 4'd1;
        default: ;
      endcase
      ganhou     <= (state_nxt == FIM_GANHOU);
      perdeu     <= (state_nxt == FIM_ERROU) || (state_nxt == FIM_TIMEOUT);
      pronto     <= (state_nxt == FIM_GANHOU) || (state_nxt == FIM_ERROU) ||
                    (state_nxt == FIM_TIMEOUT);
      db_timeout <= (state_nxt == FIM_TIMEOUT);
    end
  end

  assign leds           = jogada;
  assign db_igualjogada = igualjogada;
  assign db_igual       = igualjogada;
  assign db_igualseq    = igualseq;
  assign db_fimseq      = fimseq;
  assign db_tem_jogada  = tem_jogada;
  assign db_clock       = clock;
  assign db_iniciar     = jogar;
  assign db_contagem    = hex7seg(endereco);
  assign db_memoria     = hex7seg(rom_dado);
  assign db_estado      = hex7seg(state);
  assign db_jogadafeita = hex7seg(jogada);
  assign db_sequencia   = hex7seg(limite);

endmodule

// File: tb/tb_circuito_exp5.sv
// Directed bench for circuito_exp5: reset, start, full winning game, restart, wrong
// button, timeout window length, async reset and ignored presses.
module tb_circuito_exp5;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       jogar = 1'b0;
  logic [3:0] botoes = 4'b0000;
  logic       ganhou, perdeu, pronto, db_igual, db_clock, db_iniciar, db_fimseq;
  logic       db_igualseq, db_igualjogada, db_tem_jogada, db_timeout;
  logic [3:0] leds;
  logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_sequencia;

  int total = 0;
  int bad   = 0;

  logic [3:0] rom [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                           4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

  // seven-segment codes of the states/values used below
  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
  localparam logic [6:0] SA = 7'h08, SD = 7'h21, SE = 7'h06;

  always #5 clock = ~clock;

  circuito_exp5 dut (
    .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes),
    .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto), .leds(leds),
    .db_igual(db_igual), .db_contagem(db_contagem), .db_memoria(db_memoria),
    .db_estado(db_estado), .db_jogadafeita(db_jogadafeita), .db_sequencia(db_sequencia),
    .db_clock(db_clock), .db_iniciar(db_iniciar), .db_fimseq(db_fimseq),
    .db_igualseq(db_igualseq), .db_igualjogada(db_igualjogada),
    .db_tem_jogada(db_tem_jogada), .db_timeout(db_timeout)
  );

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    jogar = 1'b0;
    botoes = 4'b0000;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic start_game();
    jogar = 1'b1;
    @(negedge clock);
    jogar = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  // hold a button 10 cycles, release 10 cycles; count db_tem_jogada pulses seen
  task automatic press(input logic [3:0] b, output int pulses);
    pulses = 0;
    botoes = b;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (db_tem_jogada === 1'b1) pulses++;
      @(negedge clock);
    end
    botoes = 4'b0000;
    repeat (10) @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    repeat (15) @(negedge clock);
    total++; if (db_estado !== S0) begin bad++; $display("FAIL reset_state got=%h want=%h", db_estado, S0); end
    total++; if ({ganhou, perdeu, pronto} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {ganhou, perdeu, pronto}); end
    total++; if (leds !== 4'h0) begin bad++; $display("FAIL reset_leds got=%h want=0", leds); end
    total++; if (db_contagem !== S0 || db_memoria !== S1) begin bad++; $display("FAIL reset_debug got=%h/%h want=%h/%h", db_contagem, db_memoria, S0, S1); end
  endtask

  task automatic test_start();
    jogar = 1'b1;
    @(negedge clock);
    total++; if (db_estado !== S1) begin bad++; $display("FAIL start_prep got=%h want=%h", db_estado, S1); end
    @(negedge clock);
    total++; if (db_estado !== S2) begin bad++; $display("FAIL start_novaseq got=%h want=%h", db_estado, S2); end
    repeat (3) @(negedge clock);
    jogar = 1'b0;
    total++; if (db_estado !== S3) begin bad++; $display("FAIL start_espera got=%h want=%h", db_estado, S3); end
    total++; if (db_sequencia !== S0) begin bad++; $display("FAIL start_limit got=%h want=%h", db_sequencia, S0); end
  endtask

  task automatic test_full_game();
    int p;
    do_reset();
    start_game();
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j <= i; j++) press(rom[j], p);
      if (i == 0) begin
        total++; if (db_sequencia !== S1) begin bad++; $display("FAIL game_round0_limit got=%h want=%h", db_sequencia, S1); end
      end
      if (i == 14) begin
        total++; if (db_estado !== S3 || ganhou !== 1'b0) begin bad++; $display("FAIL game_round14 state=%h ganhou=%b want=%h/0", db_estado, ganhou, S3); end
      end
    end
    total++; if (db_estado !== SA) begin bad++; $display("FAIL game_final_state got=%h want=%h", db_estado, SA); end
    total++; if ({ganhou, pronto, perdeu} !== 3'b110) begin bad++; $display("FAIL game_final_flags got=%b want=110", {ganhou, pronto, perdeu}); end
    total++; if (db_fimseq !== 1'b1 || leds !== 4'h4) begin bad++; $display("FAIL game_final_fimseq got=%b/%h want=1/4", db_fimseq, leds); end
  endtask

  task automatic test_restart_from_win();
    jogar = 1'b1;
    @(negedge clock);
    jogar = 1'b0;
    total++; if (db_estado !== S1 || ganhou !== 1'b0) begin bad++; $display("FAIL restart_prep state=%h ganhou=%b want=%h/0", db_estado, ganhou, S1); end
    repeat (2) @(negedge clock);
    total++; if (db_estado !== S3) begin bad++; $display("FAIL restart_espera got=%h want=%h", db_estado, S3); end
    total++; if (db_contagem !== S0 || db_sequencia !== S0) begin bad++; $display("FAIL restart_counters got=%h/%h want=%h/%h", db_contagem, db_sequencia, S0, S0); end
    total++; if (pronto !== 1'b0) begin bad++; $display("FAIL restart_pronto got=%b want=0", pronto); end
  endtask

  task automatic test_wrong_button();
    int p;
    do_reset();
    start_game();
    press(4'b0010, p);
    total++; if (p !== 1) begin bad++; $display("FAIL wrong_pulses got=%0d want=1", p); end
    total++; if (db_estado !== SE || perdeu !== 1'b1 || pronto !== 1'b1) begin bad++; $display("FAIL wrong_state got=%h/%b/%b want=%h/1/1", db_estado, perdeu, pronto, SE); end
    total++; if (leds !== 4'b0010 || db_igualjogada !== 1'b0) begin bad++; $display("FAIL wrong_leds got=%b/%b want=0010/0", leds, db_igualjogada); end
    total++; if (db_timeout !== 1'b0 || ganhou !== 1'b0) begin bad++; $display("FAIL wrong_flags got=%b/%b want=0/0", db_timeout, ganhou); end
    press(4'b0001, p);
    total++; if (db_estado !== SE || leds !== 4'b0010) begin bad++; $display("FAIL wrong_ignored got=%h/%b want=%h/0010", db_estado, leds, SE); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    start_game();
    botoes = 4'b0001;
    @(negedge clock);
    n = 0;
    while (db_estado !== S3 && n < 20) begin
      @(negedge clock);
      n++;
    end
    total++; if (n >= 20) begin bad++; $display("FAIL timeout_reenter got=%0d cycles want<20", n); end
    botoes = 4'b0000;
    n = 0;
    while (db_estado === S3 && n < 6000) begin
      n++;
      @(negedge clock);
    end
    total++; if (n !== 5000) begin bad++; $display("FAIL timeout_window got=%0d want=5000", n); end
    repeat (5000) @(negedge clock);
    total++; if (db_estado !== SD) begin bad++; $display("FAIL timeout_state got=%h want=%h", db_estado, SD); end
    total++; if ({perdeu, db_timeout, pronto, ganhou} !== 4'b1110) begin bad++; $display("FAIL timeout_flags got=%b want=1110", {perdeu, db_timeout, pronto, ganhou}); end
  endtask

  task automatic test_async_reset();
    int p;
    do_reset();
    start_game();
    press(4'b0001, p);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    total++; if (db_estado !== S0 || leds !== 4'h0) begin bad++; $display("FAIL async_reset got=%h/%h want=%h/0", db_estado, leds, S0); end
    @(negedge clock);
    reset = 1'b0;
    press(4'b0001, p);
    total++; if (db_estado !== S0) begin bad++; $display("FAIL idle_press_ignored got=%h want=%h", db_estado, S0); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_full_game();
    test_restart_from_win();
    test_wrong_button();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
